pipe_reg_chain: RTL

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

---
 rtl/pipe_reg_chain.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage valid/ready register pipeline with bubble
// collapse, synchronous flush and a registered occupancy count.
//
// Ports
//   clk        rising-edge clock
//   clr        asynchronous active-high reset
//   in_valid   producer offers in_data
//   in_ready   chain accepts in_data this cycle (combinational, may follow out_ready)
//   in_data    input word, WIDTH bits
//   out_valid  out_data holds a valid word (last-stage valid gated by flush)
//   out_ready  consumer accepts out_data this cycle
//   out_data   data register of the last stage
//   flush      synchronous discard of every held word
//   count      number of stages holding a valid word
module pipe_reg_chain #(
   parameter int unsigned      WIDTH     = 16,
   parameter int unsigned      DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] load;
   logic             room0;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;

   // Advance chain, evaluated from the output side back to the input side.
   // 'room' means the stage below can take a word on this edge.
   always_comb begin
      logic room;
      adv  = '0;
      room = out_ready;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         adv[i] = valid_q[i] & room;
         room   = ~valid_q[i] | adv[i];
      end
      room0 = room;
   end

   // Flush and reset both block new words; clr is folded in so in_ready is
   // low for the whole reset window, not just after the registers clear.
   assign in_ready = room0 & ~flush & ~clr;

   // Stage loads and next valid bits; flush suppresses every transfer.
   always_comb begin
      load    = '0;
      valid_d = '0;
      load[0] = in_valid & in_ready;
      for (int i = 1; i < int'(DEPTH); i++) begin
         load[i] = adv[i-1] & ~flush;
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         valid_d[i] = ~flush & (load[i] | (valid_q[i] & ~adv[i]));
      end
   end

   // Occupancy of the next state, registered so count only moves on edges.
   always_comb begin
      count_d = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         count_d = count_d + CW'(valid_d[i]);
      end
   end

   // Valid bits and count.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         valid_q <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   // Data registers load only with their stage; empty stages keep stale data.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i] <= RESET_VAL;
         end
      end else begin
         if (load[0]) begin
            data_q[0] <= in_data;
         end
         for (int i = 1; i < int'(DEPTH); i++) begin
            if (load[i]) begin
               data_q[i] <= data_q[i-1];
            end
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1] & ~flush;
   assign out_data  = data_q[DEPTH-1];
   assign count     = count_q;

endmodule
